gpio_ctrl: RTL and testbench
============================

Name: gpio_ctrl

Overview:
Memory-mapped 32-bit GPIO peripheral inside the SOC, sitting between the SOC pins GPIO_IN/GPIO_OUT and the CPU data-memory bus.
- Synchronises the asynchronous GPIO_IN vector.
- Captures rising edges into sticky status bits and raises a maskable interrupt.
- Drives GPIO_OUT from a CPU-writable register.
- The CPU reads and writes it through word-aligned loads and stores.

Parameters:
WIDTH, 32, GPIO vector width (1..32)
DB_CYCLES, 4, cycles input must be stable before acceptance (debounce only; >=1)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous active-low reset (0 = reset)
ce  in  1  bus chip-enable (access this cycle)
we  in  1  1 = write, 0 = read (qualified by ce)
addr  in  4  byte address; addr[3:2] selects register, addr[1:0] ignored
wdata  in  32  write data
rdata  out  32  read data, registered
GPIO_IN  in  WIDTH  external inputs, asynchronous
GPIO_OUT  out  WIDTH  output register
irq  out  1  interrupt, registered, level

Behaviour:
- Register map (addr[3:2]):
  - 0 OUT: RW.
  - 1 IN: RO, filtered input.
  - 2 STAT: rising-edge status, write-1-to-clear.
  - 3 MASK: RW interrupt enable.
- Bits above WIDTH read 0 and are ignored on write.
- Reset (rst=0, immediate, independent of clk):
  - GPIO_OUT=0, rdata=0, irq=0.
  - STAT=0, MASK=0.
  - Synchroniser flops and IN=0; edge-detect history=0.
- Input path:
  - 2-flop synchroniser sync1 -> sync2.
  - IN <= sync2 every cycle when the debounce feature is off.
  - Latency from a GPIO_IN change to IN visible = 2 clk edges; IN readable via rdata on the following access.
- Edge detect:
  - prev <= IN each cycle.
  - rise = IN & ~prev.
  - STAT <= (STAT & ~clr) | rise.
  - clr = wdata when ce&we&addr[3:2]==2, else 0.
  - Same-cycle set and clear on a bit: set wins, bit stays 1.
  - Falling edges are not recorded.
- Writes take effect on the clk edge where ce=1, we=1:
  - OUT/MASK are replaced by wdata[WIDTH-1:0].
  - Write to IN is ignored.
- Reads use a 1-cycle latency:
  - On the edge where ce=1, we=0, rdata <= selected register. The value returned is the register contents before any same-edge updates.
  - rdata holds its value until the next read.
  - Writes do not change rdata.
- irq <= |(STAT_next & MASK_next), registered. It asserts one cycle after the STAT bit sets, or after the MASK write that enables a pending bit.
- irq deasserts one cycle after the W1C or mask write that removes the last pending & enabled bit.
- ce=0: no register changes except the input path, STAT set, and irq.
- Reset mid-access: the access is discarded, all state returns to reset values, and no partial write occurs.

Optional Feature:
GPIO_DEBOUNCE_EN
- Defined:
  - A counter (width clog2(DB_CYCLES)+1) compares sync2 with the last sampled value cand.
  - On mismatch: cand <= sync2, count <= 0.
  - On match: count increments and saturates at DB_CYCLES.
  - IN <= cand when count reaches DB_CYCLES.
  - Total input latency = 2 + DB_CYCLES + 1 edges.
  - Glitches shorter than DB_CYCLES cycles never reach IN or STAT.
  - The counter resets to 0.
- Undefined: IN <= sync2 directly and no counter logic exists.

Test Plan:
1. Reset: hold rst=0 with GPIO_IN=32'hFFFF_FFFF and toggle clk -> GPIO_OUT=0, irq=0, rdata=0. Release rst and read addr 4h4 -> 32'hFFFF_FFFF after the sync latency.
2. Write OUT=32'hA5A5_0F0F at addr 0 -> GPIO_OUT=32'hA5A5_0F0F on the next edge. Read addr 0 -> rdata=32'hA5A5_0F0F one cycle after the read edge. Write addr 4 -> no effect.
3. Edge capture: GPIO_IN 0 -> 32'h0000_0005. STAT reads 32'h0000_0005 and irq stays 0 (MASK=0). Write MASK=32'h1 -> irq=1 one cycle later. Write STAT=32'h1 -> irq=0 next cycle and STAT=32'h4.
4. Set/clear collision: a rising edge on bit 3 lands on the same edge as a W1C of 32'h8 -> STAT bit 3 remains 1.
5. Falling edge: GPIO_IN 32'h1 -> 0 -> STAT unchanged and irq unchanged.
6. With GPIO_DEBOUNCE_EN and DB_CYCLES=4:
   - 2-cycle pulse on bit 0 -> IN and STAT stay 0.
   - 10-cycle high on bit 0 -> IN bit 0 = 1 exactly 7 edges after the change, and STAT bit 0 = 1.

Source files
------------

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO block with input synchroniser, rising-edge
// sticky status (write-1-to-clear), maskable level interrupt and output register.
// Register map by addr[3:2]: 0 OUT (RW), 1 IN (RO), 2 STAT (W1C), 3 MASK (RW).
// Optional input debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_ctrl #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             we,
    input  logic [3:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [WIDTH-1:0] GPIO_IN,
    output logic [WIDTH-1:0] GPIO_OUT,
    output logic             irq
);

    typedef enum logic [1:0] {
        REG_OUT  = 2'd0,
        REG_IN   = 2'd1,
        REG_STAT = 2'd2,
        REG_MASK = 2'd3
    } reg_sel_e;

    reg_sel_e         sel;
    logic             wr_en;
    logic             rd_en;

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] in_val;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] stat_q, stat_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] out_q,  out_d;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rise;
    logic [31:0]      rdata_q, rd_val;
    logic             irq_q,   irq_d;

    // Byte lane bits and data bits above WIDTH carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata};

    assign sel   = reg_sel_e'(addr[3:2]);
    assign wr_en = ce & we;
    assign rd_en = ce & ~we;

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DB_CYCLES) + 1;

    logic [WIDTH-1:0] cand_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] in_q;

    // Debounce: accept the candidate once it has matched sync2 for DB_CYCLES
    // consecutive cycles; any change restarts the count. IN updates on the
    // same edge the count reaches DB_CYCLES.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q <= '0;
            cnt_q  <= '0;
            in_q   <= '0;
        end else if (sync2_q != cand_q) begin
            cand_q <= sync2_q;
            cnt_q  <= '0;
        end else begin
            if (cnt_q != CW'(DB_CYCLES)) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (cnt_q >= CW'(DB_CYCLES - 1)) begin
                in_q <= cand_q;
            end
        end
    end

    assign in_val = in_q;
`else
    // Without filtering, the second synchroniser stage is the IN register.
    assign in_val = sync2_q;
`endif

    // Next-state for status, mask, output and interrupt.
    always_comb begin
        clr    = '0;
        out_d  = out_q;
        mask_d = mask_q;
        if (wr_en && sel == REG_STAT) begin
            clr = wdata[WIDTH-1:0];
        end
        if (wr_en && sel == REG_OUT) begin
            out_d = wdata[WIDTH-1:0];
        end
        if (wr_en && sel == REG_MASK) begin
            mask_d = wdata[WIDTH-1:0];
        end
        rise   = in_val & ~prev_q;
        // Set is ORed after the clear so a same-cycle edge survives the W1C.
        stat_d = (stat_q & ~clr) | rise;
        irq_d  = |(stat_d & mask_d);
    end

    // Read mux: pre-update register contents, zero-extended to 32 bits.
    always_comb begin
        rd_val = '0;
        unique case (sel)
            REG_OUT:  rd_val[WIDTH-1:0] = out_q;
            REG_IN:   rd_val[WIDTH-1:0] = in_val;
            REG_STAT: rd_val[WIDTH-1:0] = stat_q;
            REG_MASK: rd_val[WIDTH-1:0] = mask_q;
        endcase
    end

    // State registers: synchroniser, edge history, CSRs, read data, interrupt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            stat_q  <= '0;
            mask_q  <= '0;
            out_q   <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync1_q <= GPIO_IN;
            sync2_q <= sync1_q;
            prev_q  <= in_val;
            stat_q  <= stat_d;
            mask_q  <= mask_d;
            out_q   <= out_d;
            irq_q   <= irq_d;
            if (rd_en) begin
                rdata_q <= rd_val;
            end
        end
    end

    assign rdata    = rdata_q;
    assign GPIO_OUT = out_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl with a transaction-level reference model.
// Define GPIO_DEBOUNCE_EN for both files to exercise the debounce filter.
module tb_gpio_ctrl;

    localparam int unsigned W  = 32;
    localparam int unsigned DB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce = 1'b0;
    logic          we = 1'b0;
    logic [3:0]    addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic [W-1:0]  gin = '0;
    logic [W-1:0]  gout;
    logic          irq;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [W-1:0]  m_out, m_mask, m_stat, m_in, m_prev;
    logic [31:0]   m_rdata;
    logic          m_irq;
    logic [W-1:0]  hist [0:DB+2];   // GPIO_IN samples, [0] = newest edge

    gpio_ctrl #(.WIDTH(W), .DB_CYCLES(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .GPIO_IN  (gin),
        .GPIO_OUT (gout),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_out = '0; m_mask = '0; m_stat = '0; m_in = '0; m_prev = '0;
        m_rdata = '0; m_irq = 1'b0;
        for (int i = 0; i <= DB + 2; i++) hist[i] = '0;
    endtask

    // Drive one bus cycle, advance the model by one edge, settle #1 past the edge.
    task automatic step(input logic c, input logic w, input logic [3:0] a,
                        input logic [31:0] d, input logic [W-1:0] g);
        logic [31:0]  rd;
        logic [W-1:0] clrv;
        logic [W-1:0] new_stat;
        logic         same;
        ce = c; we = w; addr = a; wdata = d; gin = g;
        case (a[3:2])
            2'd0:    rd = m_out;
            2'd1:    rd = m_in;
            2'd2:    rd = m_stat;
            default: rd = m_mask;
        endcase
        clrv     = (c && w && a[3:2] == 2'd2) ? d[W-1:0] : '0;
        new_stat = (m_stat & ~clrv) | (m_in & ~m_prev);
        if (c && w && a[3:2] == 2'd0) m_out  = d[W-1:0];
        if (c && w && a[3:2] == 2'd3) m_mask = d[W-1:0];
        if (c && !w) m_rdata = rd;
        m_stat = new_stat;
        m_irq  = |(m_stat & m_mask);
        m_prev = m_in;
        for (int i = DB + 2; i >= 1; i--) hist[i] = hist[i-1];
        hist[0] = g;
`ifdef GPIO_DEBOUNCE_EN
        // Filtered IN follows the synchronised value once DB+1 samples agree.
        same = 1'b1;
        for (int i = 3; i <= DB + 2; i++) if (hist[i] != hist[2]) same = 1'b0;
        if (same) m_in = hist[2];
`else
        same = 1'b1;
        m_in = hist[1];
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 32'h0, gin);
    endtask

    task automatic test_reset();
        rst = 1'b0; gin = '1; ce = 1'b0; we = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (gout !== '0) $display("FAIL reset_gpio_out: got %h expected 0", gout); else n_pass++;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else n_pass++;
        n_checks++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", rdata); else n_pass++;
        rst = 1'b1;
        idle(DB + 4);
        step(1'b1, 1'b0, 4'h4, 32'h0, gin);
        n_checks++;
        if (rdata !== 32'hFFFF_FFFF || rdata !== m_rdata)
            $display("FAIL reset_in_read: got %h expected %h", rdata, 32'hFFFF_FFFF); else n_pass++;

        // Reset asserted in the middle of a write: nothing may land.
        step(1'b1, 1'b1, 4'hC, 32'h0000_0001, gin);
        ce = 1'b1; we = 1'b1; addr = 4'h0; wdata = 32'h1234_5678;
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (gout !== '0 || irq !== 1'b0)
            $display("FAIL midreset_async: got out=%h irq=%b expected out=0 irq=0", gout, irq); else n_pass++;
        @(posedge clk);
        #1;
        ce = 1'b0; we = 1'b0;
        rst = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 4'hC, 32'h0, gin);
        n_checks++;
        if (gout !== '0 || rdata !== 32'h0)
            $display("FAIL midreset_after: got out=%h mask=%h expected 0 0", gout, rdata); else n_pass++;
        idle(DB + 4);
    endtask

    task automatic test_out();
        step(1'b1, 1'b1, 4'h0, 32'hA5A5_0F0F, gin);
        n_checks++;
        if (gout !== 32'hA5A5_0F0F) $display("FAIL out_write: got %h expected a5a50f0f", gout); else n_pass++;
        step(1'b1, 1'b0, 4'h3, 32'h0, gin);   // addr[1:0] ignored
        n_checks++;
        if (rdata !== 32'hA5A5_0F0F) $display("FAIL out_read: got %h expected a5a50f0f", rdata); else n_pass++;
        step(1'b1, 1'b1, 4'h4, 32'h0000_0000, gin);
        step(1'b1, 1'b0, 4'h4, 32'h0, gin);
        n_checks++;
        if (rdata !== m_rdata || gout !== 32'hA5A5_0F0F)
            $display("FAIL in_write_ignored: got rd=%h out=%h expected rd=%h out=a5a50f0f",
                     rdata, gout, m_rdata); else n_pass++;
    endtask

    task automatic test_edge();
        gin = '0;
        idle(DB + 6);
        step(1'b1, 1'b1, 4'h8, 32'hFFFF_FFFF, gin);
        step(1'b1, 1'b1, 4'hC, 32'h0, gin);
        gin = 32'h0000_0005;
        idle(DB + 6);
        step(1'b1, 1'b0, 4'h8, 32'h0, gin);
        n_checks++;
        if (rdata !== 32'h0000_0005) $display("FAIL edge_stat: got %h expected 5", rdata); else n_pass++;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL edge_irq_masked: got %b expected 0", irq); else n_pass++;
        step(1'b1, 1'b1, 4'hC, 32'h0000_0001, gin);
        n_checks++;
        if (irq !== 1'b1) $display("FAIL mask_irq_on: got %b expected 1", irq); else n_pass++;
        step(1'b1, 1'b1, 4'h8, 32'h0000_0001, gin);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL w1c_irq_off: got %b expected 0", irq); else n_pass++;
        step(1'b1, 1'b0, 4'h8, 32'h0, gin);
        n_checks++;
        if (rdata !== 32'h0000_0004) $display("FAIL w1c_stat: got %h expected 4", rdata); else n_pass++;
    endtask

    task automatic test_collision();
        int guard;
        step(1'b1, 1'b1, 4'h8, 32'hFFFF_FFFF, gin);
        gin = gin | 32'h8;
        guard = 0;
        while (((m_in & ~m_prev) & 32'h8) == 0 && guard < 20) begin
            idle(1);
            guard++;
        end
        n_checks++;
        if (guard >= 20) $display("FAIL collision_timeout: got %0d cycles expected <20", guard); else n_pass++;
        step(1'b1, 1'b1, 4'h8, 32'h0000_0008, gin);
        step(1'b1, 1'b0, 4'h8, 32'h0, gin);
        n_checks++;
        if (rdata[3] !== 1'b1 || rdata !== m_rdata)
            $display("FAIL collision_set_wins: got %h expected %h", rdata, m_rdata); else n_pass++;
    endtask

    task automatic test_fall();
        logic irq_before;
        step(1'b1, 1'b1, 4'hC, 32'h0000_0001, gin);
        gin = 32'h0000_0001;
        idle(DB + 6);
        step(1'b1, 1'b1, 4'h8, 32'hFFFF_FFFF, gin);
        idle(1);
        irq_before = irq;
        gin = 32'h0;
        idle(DB + 6);
        n_checks++;
        if (irq !== irq_before || irq !== m_irq)
            $display("FAIL fall_irq: got %b expected %b", irq, irq_before); else n_pass++;
        step(1'b1, 1'b0, 4'h8, 32'h0, gin);
        n_checks++;
        if (rdata !== 32'h0) $display("FAIL fall_stat: got %h expected 0", rdata); else n_pass++;
    endtask

`ifdef GPIO_DEBOUNCE_EN
    task automatic test_debounce();
        step(1'b1, 1'b1, 4'hC, 32'h0, 32'h0);
        idle(DB + 6);
        step(1'b1, 1'b1, 4'h8, 32'hFFFF_FFFF, gin);
        gin = 32'h1;
        idle(2);
        gin = 32'h0;
        idle(DB + 8);
        step(1'b1, 1'b0, 4'h4, 32'h0, gin);
        n_checks++;
        if (rdata !== 32'h0) $display("FAIL glitch_in: got %h expected 0", rdata); else n_pass++;
        step(1'b1, 1'b0, 4'h8, 32'h0, gin);
        n_checks++;
        if (rdata !== 32'h0) $display("FAIL glitch_stat: got %h expected 0", rdata); else n_pass++;
        gin = 32'h1;
        idle(6);
        step(1'b1, 1'b0, 4'h4, 32'h0, gin);   // edge 7: returns IN before the update
        n_checks++;
        if (rdata !== 32'h0) $display("FAIL db_early: got %h expected 0", rdata); else n_pass++;
        step(1'b1, 1'b0, 4'h4, 32'h0, gin);   // edge 8: IN updated on edge 7
        n_checks++;
        if (rdata !== 32'h1) $display("FAIL db_accept: got %h expected 1", rdata); else n_pass++;
        idle(2);
        gin = 32'h0;
        step(1'b1, 1'b0, 4'h8, 32'h0, gin);
        n_checks++;
        if (rdata[0] !== 1'b1) $display("FAIL db_stat: got %h expected bit0=1", rdata); else n_pass++;
        idle(DB + 6);
    endtask
`endif

    task automatic test_random();
        logic          c, w;
        logic [3:0]    a;
        logic [31:0]   d;
        logic [W-1:0]  g;
        int            errs;
        errs = 0;
        g = gin;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) g = g ^ (W'(1) << $urandom_range(0, W - 1));
                else g = $urandom;
            end
            c = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1);
            a = 4'($urandom);
            d = $urandom;
            if (a[3:2] == 2'd2 && $urandom_range(0, 1) == 0) d = d & 32'h0000_00FF;
            step(c, w, a, d, g);
            n_checks++;
            if (rdata !== m_rdata || gout !== m_out || irq !== m_irq) begin
                if (errs < 10)
                    $display("FAIL random_cycle%0d: got rd=%h out=%h irq=%b expected rd=%h out=%h irq=%b",
                             i, rdata, gout, irq, m_rdata, m_out, m_irq);
                errs++;
            end else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b1, 4'h0, 32'h1357_9BDF, gin);
        step(1'b1, 1'b1, 4'hC, 32'h0F0F_0F0F, gin);
        step(1'b1, 1'b0, 4'h0, 32'h0, gin);
        n_checks++;
        if (rdata !== 32'h1357_9BDF) $display("FAIL b2b_out: got %h expected 13579bdf", rdata); else n_pass++;
        step(1'b1, 1'b0, 4'hC, 32'h0, gin);
        n_checks++;
        if (rdata !== 32'h0F0F_0F0F) $display("FAIL b2b_mask: got %h expected 0f0f0f0f", rdata); else n_pass++;
        step(1'b1, 1'b1, 4'h0, 32'h0, gin);   // write keeps rdata
        n_checks++;
        if (rdata !== 32'h0F0F_0F0F) $display("FAIL b2b_write_holds: got %h expected 0f0f0f0f", rdata); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_out();
        test_edge();
        test_collision();
        test_fall();
`ifdef GPIO_DEBOUNCE_EN
        test_debounce();
`endif
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
